dense_sequencer: RTL and testbench

DENSE_SEQUENCER -- requirements
Module: dense_sequencer

---
 rtl/dense_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_dense_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_sequencer.sv
`default_nettype none
// ============================================================================
// dense_sequencer: runs NUM_OUTPUTS neurons through an external dense unit,
// gathering weights/bias from 1-cycle ROMs. Macro DENSE_SEQ_RELU_EN clamps
// negative results to zero.
// Revision: 1.0
// ============================================================================
module dense_sequencer #(
  parameter int N           = 16,
  parameter int Q           = 8,
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  localparam int c_WA_W  = (NUM_OUTPUTS * NUM_INPUTS > 1) ? $clog2(NUM_OUTPUTS * NUM_INPUTS) : 1,
  localparam int c_BA_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
  localparam int c_VEC_W = N * NUM_INPUTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [c_VEC_W-1:0] in_vec,
  output logic               busy,
  output logic               done,
  output logic [c_WA_W-1:0]  w_addr,
  input  logic [N-1:0]       w_data,
  output logic [c_BA_W-1:0]  b_addr,
  input  logic [N-1:0]       b_data,
  output logic               d_start,
  output logic [c_VEC_W-1:0] d_input_vec,
  output logic [c_VEC_W-1:0] d_weight_vec,
  output logic [N-1:0]       d_bias,
  input  logic               d_done,
  input  logic [N-1:0]       d_output,
  output logic               res_valid,
  output logic [c_BA_W-1:0]  res_idx,
  output logic [N-1:0]       res_data
);

  localparam int c_CNT_W = $clog2(NUM_INPUTS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Q only names the fixed-point format; results pass through unscaled.
  generate
    if (Q >= N) begin : g_q_exceeds_width
    end
  endgenerate

  state_t               state_q, state_d;
  logic [c_BA_W-1:0]    j_q, j_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_WA_W-1:0]    waddr_q, waddr_d;
  logic [c_BA_W-1:0]    baddr_q, baddr_d;
  logic [c_VEC_W-1:0]   in_q, in_d;
  logic [c_VEC_W-1:0]   wv_q, wv_d;
  logic [N-1:0]         bias_q, bias_d;
  logic [N-1:0]         res_q, res_d;

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    baddr_d   = baddr_q;
    in_d      = in_q;
    wv_d      = wv_q;
    bias_d    = bias_q;
    res_d     = res_q;
    busy      = 1'b0;
    done      = 1'b0;
    d_start   = 1'b0;
    res_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          in_d    = in_vec;
          j_d     = '0;
          cnt_d   = '0;
          waddr_d = '0;
          baddr_d = '0;
        end
      end

      FETCH: begin
        busy = 1'b1;
        // ROM data lags its address by one cycle, so cycle c lands element c-1.
        for (int k = 0; k < NUM_INPUTS; k++) begin
          if (cnt_q == c_CNT_W'(k + 1)) begin
            wv_d[k*N +: N] = w_data;
          end
        end
        if (cnt_q == c_CNT_W'(1)) begin
          bias_d = b_data;
        end
        if (cnt_q < c_CNT_W'(NUM_INPUTS - 1)) begin
          waddr_d = waddr_q + c_WA_W'(1);
        end
        if (cnt_q == c_CNT_W'(NUM_INPUTS)) begin
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      ISSUE: begin
        busy    = 1'b1;
        d_start = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        busy = 1'b1;
        if (d_done) begin
`ifdef DENSE_SEQ_RELU_EN
          res_d = d_output[N-1] ? '0 : d_output;
`else
          res_d = d_output;
`endif
          state_d = STORE;
        end
      end

      STORE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (j_q == c_BA_W'(NUM_OUTPUTS - 1)) begin
          state_d = FIN;
        end else begin
          // Neuron weights are contiguous, so the next base is one past the last.
          j_d     = j_q + c_BA_W'(1);
          baddr_d = j_q + c_BA_W'(1);
          waddr_d = waddr_q + c_WA_W'(1);
          cnt_d   = '0;
          state_d = FETCH;
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      j_q     <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      baddr_q <= '0;
      in_q    <= '0;
      wv_q    <= '0;
      bias_q  <= '0;
      res_q   <= '0;
    end else begin
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      baddr_q <= baddr_d;
      in_q    <= in_d;
      wv_q    <= wv_d;
      bias_q  <= bias_d;
      res_q   <= res_d;
    end
  end

  assign w_addr       = waddr_q;
  assign b_addr       = baddr_q;
  assign d_input_vec  = in_q;
  assign d_weight_vec = wv_q;
  assign d_bias       = bias_q;
  assign res_idx      = j_q;
  assign res_data     = res_q;

endmodule
`default_nettype wire

// File: tb/tb_dense_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dense_sequencer: randomized self-checking bench with ROM and dense-unit
// models and a neuron-level reference. Honours DENSE_SEQ_RELU_EN.
// Revision: 1.0
// ============================================================================
module tb_dense_sequencer;

  localparam int N    = 16;
  localparam int Q    = 8;
  localparam int NI   = 4;
  localparam int NO   = 4;
  localparam int WA_W = 4;
  localparam int BA_W = 2;
  localparam int VW   = N * NI;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [VW-1:0]   in_vec = '0;
  logic            busy, done, d_start, res_valid;
  logic [WA_W-1:0] w_addr;
  logic [BA_W-1:0] b_addr, res_idx;
  logic [N-1:0]    w_data = '0, b_data = '0, d_bias, res_data;
  logic [N-1:0]    d_output = '0;
  logic            d_done = 1'b0;
  logic [VW-1:0]   d_input_vec, d_weight_vec;

  int n_err = 0;
  int n_chk = 0;

  logic [N-1:0] wrom [NO*NI];
  logic [N-1:0] brom [NO];
  logic [N-1:0] last_dat [NO];

  int            lat_cfg  = 1;
  bit            noise_en = 1'b0;
  int            stub_cnt = 0;
  logic          real_done = 1'b0;
  logic [N-1:0]  stub_val = '0;
  logic [VW-1:0] cap_in = '0, cap_w = '0;
  logic [N-1:0]  cap_b = '0;

  dense_sequencer #(.N(N), .Q(Q), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
    .busy(busy), .done(done), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .d_start(d_start),
    .d_input_vec(d_input_vec), .d_weight_vec(d_weight_vec), .d_bias(d_bias),
    .d_done(d_done), .d_output(d_output), .res_valid(res_valid),
    .res_idx(res_idx), .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Fixed-point neuron: sum of Q-scaled products, rescaled, plus bias, wrapped to N bits.
  function automatic logic [N-1:0] dense_math(input logic [VW-1:0] x, input logic [VW-1:0] w,
                                              input logic [N-1:0] b);
    longint acc = 0;
    for (int k = 0; k < NI; k++)
      acc += longint'($signed(x[k*N +: N])) * longint'($signed(w[k*N +: N]));
    acc = (acc >>> Q) + longint'($signed(b));
    return acc[N-1:0];
  endfunction

  function automatic logic [N-1:0] neuron_ref(input int j, input logic [VW-1:0] x);
    logic [VW-1:0] w;
    logic [N-1:0]  r;
    for (int k = 0; k < NI; k++) w[k*N +: N] = wrom[j*NI + k];
    r = dense_math(x, w, brom[j]);
`ifdef DENSE_SEQ_RELU_EN
    if (r[N-1]) r = '0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  // Dense unit model: fixed latency after d_start, junk on d_output otherwise.
  always @(posedge clk) begin
    d_done    <= 1'b0;
    real_done <= 1'b0;
    d_output  <= N'($urandom);
    if (d_start) begin
      stub_cnt <= lat_cfg;
      stub_val <= dense_math(d_input_vec, d_weight_vec, d_bias);
      cap_in   <= d_input_vec;
      cap_w    <= d_weight_vec;
      cap_b    <= d_bias;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        d_done    <= 1'b1;
        real_done <= 1'b1;
        d_output  <= stub_val;
      end
    end else if (noise_en && $urandom_range(0, 2) == 0) begin
      d_done <= 1'b1;
    end
  end

  task automatic check_zero(input string p);
    check_val({p, ":busy"},    64'(busy), 64'd0);
    check_val({p, ":done"},    64'(done), 64'd0);
    check_val({p, ":d_start"}, 64'(d_start), 64'd0);
    check_val({p, ":res_vld"}, 64'(res_valid), 64'd0);
    check_val({p, ":res_idx"}, 64'(res_idx), 64'd0);
    check_val({p, ":res_dat"}, 64'(res_data), 64'd0);
    check_val({p, ":w_addr"},  64'(w_addr), 64'd0);
    check_val({p, ":b_addr"},  64'(b_addr), 64'd0);
    check_val({p, ":d_bias"},  64'(d_bias), 64'd0);
    check_val({p, ":d_wvec"},  64'(d_weight_vec), 64'd0);
    check_val({p, ":d_ivec"},  64'(d_input_vec), 64'd0);
  endtask

  task automatic randomize_rom();
    for (int i = 0; i < NO*NI; i++) wrom[i] = N'($urandom);
    for (int i = 0; i < NO; i++) brom[i] = N'($urandom);
  endtask

  task automatic run_check(input string tag, input int lat, input bit noisy, input logic [VW-1:0] x);
    logic [N-1:0]    exp_v [NO];
    int              got_idx [$];
    logic [N-1:0]    got_dat [$];
    int              cyc = 0, n_done = 0, done_cyc = -1, last_res_cyc = -10;
    int              ds_hi = 0, ds_rise = 0, stab_err = 0, addr_err = 0, n_addr = 0, busy_at_done = 0;
    logic            prev_ds = 1'b0;
    logic [WA_W-1:0] last_addr = '0;
    bit              have_addr = 1'b0;

    for (int j = 0; j < NO; j++) exp_v[j] = neuron_ref(j, x);
    lat_cfg  = lat;
    noise_en = noisy;
    @(negedge clk);
    in_vec = x;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, ":busy_on_start"}, 64'(busy), 64'd1);

    while (cyc < 2000 && !(n_done > 0 && cyc > done_cyc + 3)) begin
      if (busy && (!have_addr || w_addr != last_addr)) begin
        if (w_addr != WA_W'(n_addr)) addr_err++;
        n_addr++;
        last_addr = w_addr;
        have_addr = 1'b1;
      end
      if (d_start) ds_hi++;
      if (d_start && !prev_ds) ds_rise++;
      prev_ds = d_start;
      if (stub_cnt != 0 || real_done)
        if (d_input_vec != cap_in || d_weight_vec != cap_w || d_bias != cap_b) stab_err++;
      if (res_valid) begin
        got_idx.push_back(int'(res_idx));
        got_dat.push_back(res_data);
        last_res_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (busy) busy_at_done++;
      end
      if (noisy) begin
        in_vec = {$urandom, $urandom};
        start  = busy && ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    noise_en = 1'b0;

    check_val({tag, ":done_count"}, 64'(n_done), 64'd1);
    check_val({tag, ":done_after_last"}, 64'(done_cyc), 64'(last_res_cyc + 1));
    check_val({tag, ":busy_at_done"}, 64'(busy_at_done), 64'd0);
    check_val({tag, ":res_count"}, 64'(got_idx.size()), 64'(NO));
    for (int j = 0; j < NO; j++) begin
      if (j < got_idx.size()) begin
        check_val($sformatf("%s:idx%0d", tag, j), 64'(got_idx[j]), 64'(j));
        check_val($sformatf("%s:data%0d", tag, j), 64'(got_dat[j]), 64'(exp_v[j]));
        last_dat[j] = got_dat[j];
      end else begin
        last_dat[j] = 'x;
      end
    end
    check_val({tag, ":dstart_pulses"}, 64'(ds_rise), 64'(NO));
    check_val({tag, ":dstart_cycles"}, 64'(ds_hi), 64'(NO));
    check_val({tag, ":waddr_steps"}, 64'(n_addr), 64'(NO*NI));
    check_val({tag, ":waddr_order"}, 64'(addr_err), 64'd0);
    check_val({tag, ":operands_stable"}, 64'(stab_err), 64'd0);
  endtask

  task automatic reset_mid_run();
    int ds = 0;
    int cyc = 0;
    int stray = 0;
    lat_cfg  = 20;
    noise_en = 1'b0;
    randomize_rom();
    @(negedge clk);
    in_vec = {$urandom, $urandom};
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (ds < 3 && cyc < 500) begin
      if (d_start) ds++;
      if (ds < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_val("rst_mid:reached_neuron2", 64'(ds), 64'd3);
    repeat (3) @(negedge clk);
    check_val("rst_mid:in_wait", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || done || busy) stray++;
    end
    check_val("rst_mid:no_stray_output", 64'(stray), 64'd0);
  endtask

  initial begin
    logic [VW-1:0] xd;
    logic [N-1:0]  lat1_dat [NO];

    randomize_rom();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Directed neurons: in = [1,2,3,4]; n0 = [0.5,1,0.75,-0.5]+0.25; n1 = all -0.5 +0.25.
    xd = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    wrom[0] = 16'h0080; wrom[1] = 16'h0100; wrom[2] = 16'h00C0; wrom[3] = 16'hFF80;
    brom[0] = 16'h0040;
    for (int k = 4; k < 8; k++) wrom[k] = 16'hFF80;
    brom[1] = 16'h0040;
    run_check("dir_lat1", 1, 1'b0, xd);
    check_val("dir:n0_3p0", 64'(last_dat[0]), 64'h0300);
`ifdef DENSE_SEQ_RELU_EN
    check_val("dir:n1_relu", 64'(last_dat[1]), 64'h0000);
`else
    check_val("dir:n1_neg", 64'(last_dat[1]), 64'hFB40);
`endif
    for (int j = 0; j < NO; j++) lat1_dat[j] = last_dat[j];

    run_check("dir_lat20", 20, 1'b0, xd);
    for (int j = 0; j < NO; j++)
      check_val($sformatf("lat_invariant%0d", j), 64'(last_dat[j]), 64'(lat1_dat[j]));

    randomize_rom();
    run_check("rnd_noisy_lat1", 1, 1'b1, {$urandom, $urandom});
    for (int r = 0; r < 3; r++) begin
      randomize_rom();
      run_check($sformatf("rnd%0d", r), int'($urandom_range(1, 20)), 1'b1, {$urandom, $urandom});
    end

    reset_mid_run();
    randomize_rom();
    run_check("after_reset", 3, 1'b1, {$urandom, $urandom});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
